// File: rtl/alu_result_tx.sv
// ============================================================================
// Module      : alu_result_tx
// Description : Serialises 16-bit ALU results into a valid/ready byte stream,
//               with a 1-entry pending buffer and a saturating drop counter.
//               Optional checksum byte: define ALU_RESULT_TX_CHKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_tx #(
  parameter int MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] ALU_OUT,
  input  logic        OUT_Valid,
  input  logic        TX_Ready,
  output logic [7:0]  TX_DATA,
  output logic        TX_Valid,
  output logic        Busy,
  output logic [7:0]  Drop_Cnt
);

`ifdef ALU_RESULT_TX_CHKSUM_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_B0  = 2'd1,
    SEND_B1  = 2'd2,
    SEND_CHK = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_B0 = 2'd1,
    SEND_B1 = 2'd2
  } state_t;
`endif

  localparam logic [7:0] c_drop_max = 8'hFF;

  state_t      r_state;
  logic [15:0] r_active;
  logic [15:0] r_pend;
  logic        r_pend_full;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [7:0]  r_drop_cnt;

  state_t      w_state_nxt;
  logic [15:0] w_active_nxt;
  logic [15:0] w_pend_nxt;
  logic        w_pend_full_nxt;
  logic [7:0]  w_tx_data_nxt;
  logic        w_tx_valid_nxt;
  logic [7:0]  w_drop_nxt;
  logic        w_xfer;
  logic        w_last;

  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return (MSB_FIRST != 0) ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return (MSB_FIRST != 0) ? w[7:0] : w[15:8];
  endfunction

  assign w_xfer = r_tx_valid & TX_Ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_active_nxt    = r_active;
    w_pend_nxt      = r_pend;
    w_pend_full_nxt = r_pend_full;
    w_tx_data_nxt   = r_tx_data;
    w_tx_valid_nxt  = r_tx_valid;
    w_drop_nxt      = r_drop_cnt;
    w_last          = 1'b0;

    case (r_state)
      IDLE: begin
        if (OUT_Valid) begin
          w_active_nxt   = ALU_OUT;
          w_state_nxt    = SEND_B0;
          w_tx_data_nxt  = first_byte(ALU_OUT);
          w_tx_valid_nxt = 1'b1;
        end
      end
      SEND_B0: begin
        if (w_xfer) begin
          w_state_nxt   = SEND_B1;
          w_tx_data_nxt = second_byte(r_active);
        end
      end
      SEND_B1: begin
        if (w_xfer) begin
`ifdef ALU_RESULT_TX_CHKSUM_EN
          w_state_nxt   = SEND_CHK;
          w_tx_data_nxt = r_active[15:8] ^ r_active[7:0];
`else
          w_last        = 1'b1;
`endif
        end
      end
`ifdef ALU_RESULT_TX_CHKSUM_EN
      SEND_CHK: begin
        w_last = w_xfer;
      end
`endif
      default: begin
        w_state_nxt    = IDLE;
        w_tx_valid_nxt = 1'b0;
      end
    endcase

    // Last byte leaving frees the active slot, so a new word never drops here.
    if (w_last) begin
      if (r_pend_full) begin
        w_active_nxt    = r_pend;
        w_state_nxt     = SEND_B0;
        w_tx_data_nxt   = first_byte(r_pend);
        w_tx_valid_nxt  = 1'b1;
        w_pend_full_nxt = OUT_Valid;
        if (OUT_Valid) begin
          w_pend_nxt = ALU_OUT;
        end
      end else if (OUT_Valid) begin
        w_active_nxt   = ALU_OUT;
        w_state_nxt    = SEND_B0;
        w_tx_data_nxt  = first_byte(ALU_OUT);
        w_tx_valid_nxt = 1'b1;
      end else begin
        w_state_nxt    = IDLE;
        w_tx_valid_nxt = 1'b0;
      end
    end else if ((r_state != IDLE) && OUT_Valid) begin
      if (!r_pend_full) begin
        w_pend_nxt      = ALU_OUT;
        w_pend_full_nxt = 1'b1;
      end else if (r_drop_cnt != c_drop_max) begin
        w_drop_nxt = r_drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state     <= IDLE;
      r_active    <= 16'h0000;
      r_pend      <= 16'h0000;
      r_pend_full <= 1'b0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_drop_cnt  <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_drop_cnt  <= w_drop_nxt;
    end
  end

  assign TX_DATA  = r_tx_data;
  assign TX_Valid = r_tx_valid;
  assign Busy     = (r_state != IDLE) || r_pend_full;
  assign Drop_Cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_tx.sv
// ============================================================================
// Module      : tb_alu_result_tx
// Description : Word-queue reference model bench for alu_result_tx, run on an
//               LSB-first and an MSB-first instance sharing the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_tx;

`ifdef ALU_RESULT_TX_CHKSUM_EN
  localparam int c_nb = 3;
`else
  localparam int c_nb = 2;
`endif

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        OUT_Valid = 1'b0;
  logic        TX_Ready = 1'b0;

  logic [7:0]  tx_data0, tx_data1, drop0, drop1;
  logic        tx_valid0, tx_valid1, busy0, busy1;

  always #5 clk = ~clk;

  alu_result_tx #(.MSB_FIRST(0)) u_dut_lsb (
    .clk(clk), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .TX_Ready(TX_Ready), .TX_DATA(tx_data0), .TX_Valid(tx_valid0),
    .Busy(busy0), .Drop_Cnt(drop0)
  );

  alu_result_tx #(.MSB_FIRST(1)) u_dut_msb (
    .clk(clk), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .TX_Ready(TX_Ready), .TX_DATA(tx_data1), .TX_Valid(tx_valid1),
    .Busy(busy1), .Drop_Cnt(drop1)
  );

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Model: the words held by the block (active first), byte index, drop count.
  logic [15:0] mq[$];
  int          midx = 0;
  int          mdrop = 0;
  bit          mzero = 1;

  logic [7:0] log0[$];
  logic [7:0] log1[$];

  function automatic logic [7:0] exp_byte(input logic [15:0] w, input int idx, input bit msb);
    logic [7:0] lo, hi;
    lo = w[7:0];
    hi = w[15:8];
    if (idx == 0) return msb ? hi : lo;
    if (idx == 1) return msb ? lo : hi;
    return lo ^ hi;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_log(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
    int bad;
    bad = -1;
    if (got.size() != exp.size()) bad = 0;
    else foreach (exp[i]) if (bad < 0 && got[i] !== exp[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s actual_len=%0d required_len=%0d first_bad_idx=%0d actual=%h required=%h",
               name, got.size(), exp.size(), bad,
               (bad < got.size()) ? got[bad] : 8'hxx, (bad < exp.size()) ? exp[bad] : 8'hxx);
    end
  endtask

  always @(posedge clk) begin
    bit xfer;
    if (RST) begin
      mq.delete();
      midx  = 0;
      mdrop = 0;
      mzero = 1;
    end else begin
      xfer = (mq.size() > 0) && TX_Ready;
      if (xfer) begin
        if (midx == c_nb - 1) begin
          void'(mq.pop_front());
          midx = 0;
        end else begin
          midx++;
        end
      end
      if (OUT_Valid) begin
        if (mq.size() < 2) mq.push_back(ALU_OUT);
        else if (mdrop < 255) mdrop++;
      end
      if (mq.size() > 0) mzero = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("tx_valid_lsb", {15'd0, tx_valid0}, {15'd0, mq.size() > 0});
      check("tx_valid_msb", {15'd0, tx_valid1}, {15'd0, mq.size() > 0});
      check("busy_lsb", {15'd0, busy0}, {15'd0, mq.size() > 0});
      check("busy_msb", {15'd0, busy1}, {15'd0, mq.size() > 0});
      check("drop_lsb", {8'd0, drop0}, mdrop[15:0]);
      check("drop_msb", {8'd0, drop1}, mdrop[15:0]);
      if (mq.size() > 0) begin
        check("tx_data_lsb", {8'd0, tx_data0}, {8'd0, exp_byte(mq[0], midx, 1'b0)});
        check("tx_data_msb", {8'd0, tx_data1}, {8'd0, exp_byte(mq[0], midx, 1'b1)});
      end else if (mzero) begin
        check("tx_data_rst_lsb", {8'd0, tx_data0}, 16'h0000);
        check("tx_data_rst_msb", {8'd0, tx_data1}, 16'h0000);
      end
    end
    if (!RST && TX_Ready) begin
      if (tx_valid0) log0.push_back(tx_data0);
      if (tx_valid1) log1.push_back(tx_data1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    OUT_Valid = 1'b0;
    TX_Ready = 1'b0;
    tick();
    RST = 1'b0;
    log0.delete();
    log1.delete();
  endtask

  task automatic send(input logic [15:0] w);
    ALU_OUT = w;
    OUT_Valid = 1'b1;
    tick();
    OUT_Valid = 1'b0;
  endtask

  initial begin
    logic [7:0] e[$];
    #200000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e[$];
    tick();
    started = 1;
    do_reset();
    check("reset_valid", {15'd0, tx_valid0}, 16'h0000);
    check("reset_busy", {15'd0, busy0}, 16'h0000);
    check("reset_data", {8'd0, tx_data0}, 16'h0000);

    // Single word with a free-running sink.
    TX_Ready = 1'b1;
    send(16'hA55A);
    repeat (6) tick();
`ifdef ALU_RESULT_TX_CHKSUM_EN
    e = '{8'h5A, 8'hA5, 8'hFF};
`else
    e = '{8'h5A, 8'hA5};
`endif
    check_log("single_word", log0, e);
    check("single_busy", {15'd0, busy0}, 16'h0000);

    // Three words into a stalled sink: third is dropped.
    do_reset();
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    tick();
    check("stall_drop", {8'd0, drop0}, 16'h0001);
    TX_Ready = 1'b1;
    repeat (12) tick();
`ifdef ALU_RESULT_TX_CHKSUM_EN
    e = '{8'h11, 8'h11, 8'h00, 8'h22, 8'h22, 8'h00};
`else
    e = '{8'h11, 8'h11, 8'h22, 8'h22};
`endif
    check_log("stall_order", log0, e);

    // New word arrives exactly on the last-byte transfer.
    do_reset();
    TX_Ready = 1'b1;
    send(16'h1234);
    repeat (c_nb - 1) tick();
    send(16'hBEEF);
    repeat (8) tick();
`ifdef ALU_RESULT_TX_CHKSUM_EN
    e = '{8'h34, 8'h12, 8'h26, 8'hEF, 8'hBE, 8'h51};
`else
    e = '{8'h34, 8'h12, 8'hEF, 8'hBE};
`endif
    check_log("back_to_back", log0, e);

    // Byte order parameter.
    do_reset();
    TX_Ready = 1'b1;
    send(16'hC0DE);
    repeat (6) tick();
`ifdef ALU_RESULT_TX_CHKSUM_EN
    e = '{8'hC0, 8'hDE, 8'h1E};
`else
    e = '{8'hC0, 8'hDE};
`endif
    check_log("msb_first", log1, e);

    // Reset mid-word abandons the rest of it.
    do_reset();
    TX_Ready = 1'b1;
    send(16'hA55A);
    tick();
    RST = 1'b1;
    TX_Ready = 1'b0;
    tick();
    RST = 1'b0;
    check("midreset_valid", {15'd0, tx_valid0}, 16'h0000);
    check("midreset_drop", {8'd0, drop0}, 16'h0000);
    TX_Ready = 1'b1;
    repeat (6) tick();
    e = '{8'h5A};
    check_log("midreset_log", log0, e);

    // Drop counter saturation.
    do_reset();
    ALU_OUT = 16'h7777;
    OUT_Valid = 1'b1;
    repeat (302) tick();
    OUT_Valid = 1'b0;
    check("drop_sat_lsb", {8'd0, drop0}, 16'h00FF);
    check("drop_sat_msb", {8'd0, drop1}, 16'h00FF);

    // Randomised traffic, occasional resets, bursty backpressure.
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      RST       = ($urandom_range(0, 199) == 0);
      OUT_Valid = $urandom_range(0, 1);
      ALU_OUT   = 16'($urandom());
      TX_Ready  = ((i / 64) % 3 == 2) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      tick();
    end
    RST = 1'b0;
    OUT_Valid = 1'b0;
    TX_Ready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
